// File: rtl/phys_reg_free_list_pkg.sv
// phys_reg_free_list_pkg
//   Shared sizing and types for the physical register free list.
//   NUM_PHYS_REGS   : total physical registers (tag width = log2 of this)
//   NUM_ARCH_REGS   : architectural registers, mapped to phys 0..N-1 at reset
//   FREE_LIST_DEPTH : FIFO capacity; must be a power of two so the
//                     wrap-bit pointer scheme works
package phys_reg_free_list_pkg;

  localparam int NUM_PHYS_REGS   = 64;
  localparam int NUM_ARCH_REGS   = 32;
  localparam int FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;

  localparam int TAG_W = $clog2(NUM_PHYS_REGS);
  localparam int IDX_W = $clog2(FREE_LIST_DEPTH);
  localparam int PTR_W = IDX_W + 1;                   // MSB is the wrap bit
  localparam int CNT_W = $clog2(FREE_LIST_DEPTH + 1); // holds 0..DEPTH

  typedef logic [TAG_W-1:0] phys_reg_tag_t;
  typedef logic [PTR_W-1:0] free_list_ptr_t;
  typedef logic [CNT_W-1:0] free_count_t;

  // One tag-return request (commit or revert path).
  typedef struct packed {
    logic          valid;
    phys_reg_tag_t tag;
  } free_req_t;

  // Storage index of a wrap-bit pointer.
  function automatic logic [IDX_W-1:0] ptr_idx(input free_list_ptr_t p);
    return p[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// phys_reg_free_list_if
//   Bundles the allocate handshake, the two tag-return paths and the status
//   outputs of the free list.
//   slave  : free list side (drives alloc_*, free_count, DUT_error)
//   master : dispatch / ROB side (drives alloc_ready and the free paths)
interface phys_reg_free_list_if;
  import phys_reg_free_list_pkg::*;

  logic          alloc_valid;
  phys_reg_tag_t alloc_phys_reg_tag;
  logic          alloc_ready;

  logic          commit_free_valid;
  phys_reg_tag_t commit_free_phys_reg_tag;
  logic          revert_free_valid;
  phys_reg_tag_t revert_free_phys_reg_tag;

  free_count_t   free_count;
  logic          DUT_error;

  modport slave (
    output alloc_valid, alloc_phys_reg_tag, free_count, DUT_error,
    input  alloc_ready,
    input  commit_free_valid, commit_free_phys_reg_tag,
    input  revert_free_valid, revert_free_phys_reg_tag
  );

  modport master (
    input  alloc_valid, alloc_phys_reg_tag, free_count, DUT_error,
    output alloc_ready,
    output commit_free_valid, commit_free_phys_reg_tag,
    output revert_free_valid, revert_free_phys_reg_tag
  );

endinterface

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list
//   Circular FIFO of unmapped physical register tags feeding the rename map
//   table. One tag may leave per cycle (dispatch); up to two may return per
//   cycle (ROB commit and ROB revert), commit first.
//   CLK : clock, all state on posedge
//   RST : asynchronous active-high reset; restores the post-reset full list
//   fl  : slave side of phys_reg_free_list_if
//         alloc_valid / alloc_phys_reg_tag : head of the FIFO
//         alloc_ready                      : head consumed this cycle
//         commit_free_* / revert_free_*    : tag return paths
//         free_count                       : registered occupancy (0..DEPTH)
//         DUT_error                        : registered, high the cycle
//                                            after any illegal event
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input logic                 CLK,
  input logic                 RST,
  phys_reg_free_list_if.slave fl
);

  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(FREE_LIST_DEPTH);

  phys_reg_tag_t            r_entry [FREE_LIST_DEPTH];
  free_list_ptr_t           r_head;
  free_list_ptr_t           r_tail;
  logic [NUM_PHYS_REGS-1:0] r_is_free;
  free_count_t              r_free_count;
  logic                     r_dut_error;

  free_req_t      w_commit;
  free_req_t      w_revert;
  logic           w_empty;
  logic           w_deq;
  logic           w_c_ok;
  logic           w_r_ok;
  logic           w_next_err;
  logic [CNT_W:0] w_cnt_sum;
  free_list_ptr_t w_r_slot;
  free_list_ptr_t w_tail_next;
  free_list_ptr_t w_head_next;
  phys_reg_tag_t  w_head_tag;

  assign w_commit = '{valid: fl.commit_free_valid, tag: fl.commit_free_phys_reg_tag};
  assign w_revert = '{valid: fl.revert_free_valid, tag: fl.revert_free_phys_reg_tag};

  assign w_empty    = (r_head == r_tail);
  assign w_head_tag = r_entry[ptr_idx(r_head)];

  // No enqueue->dequeue bypass: the head is always read from registered state.
  assign fl.alloc_valid        = ~w_empty;
  assign fl.alloc_phys_reg_tag = w_head_tag;
  assign fl.free_count         = r_free_count;
  assign fl.DUT_error          = r_dut_error;

  always_comb begin
    w_next_err = 1'b0;

    w_deq = fl.alloc_ready & ~w_empty;
    if (fl.alloc_ready && w_empty) w_next_err = 1'b1;

    // Legality is judged against the pre-edge bitmap, so a tag leaving the
    // head this cycle cannot be legally returned in the same cycle.
    w_c_ok = w_commit.valid;
    if (w_commit.valid && (w_commit.tag == '0 || r_is_free[w_commit.tag])) begin
      w_c_ok     = 1'b0;
      w_next_err = 1'b1;
    end

    w_r_ok = w_revert.valid;
    if (w_revert.valid && (w_revert.tag == '0 || r_is_free[w_revert.tag])) begin
      w_r_ok     = 1'b0;
      w_next_err = 1'b1;
    end

    // Same tag on both paths: commit wins.
    if (w_commit.valid && w_revert.valid && (w_commit.tag == w_revert.tag)) begin
      w_r_ok     = 1'b0;
      w_next_err = 1'b1;
    end

    // Occupancy never underflows here: w_deq implies a non-zero count.
    w_cnt_sum = {1'b0, r_free_count} - (CNT_W+1)'(w_deq)
              + (CNT_W+1)'(w_c_ok) + (CNT_W+1)'(w_r_ok);

    // Overflow sheds the revert tag first, then commit.
    if (w_cnt_sum > DEPTH_LIM && w_r_ok) begin
      w_r_ok     = 1'b0;
      w_next_err = 1'b1;
      w_cnt_sum  = w_cnt_sum - (CNT_W+1)'(1);
    end
    if (w_cnt_sum > DEPTH_LIM && w_c_ok) begin
      w_c_ok     = 1'b0;
      w_next_err = 1'b1;
      w_cnt_sum  = w_cnt_sum - (CNT_W+1)'(1);
    end

    // Revert lands behind commit when both are accepted.
    w_r_slot    = r_tail + free_list_ptr_t'(w_c_ok);
    w_tail_next = w_r_slot + free_list_ptr_t'(w_r_ok);
    w_head_next = r_head + free_list_ptr_t'(w_deq);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FREE_LIST_DEPTH; i++)
        r_entry[i] <= phys_reg_tag_t'(NUM_ARCH_REGS + i);
    end else begin
      if (w_c_ok) r_entry[ptr_idx(r_tail)]   <= w_commit.tag;
      if (w_r_ok) r_entry[ptr_idx(w_r_slot)] <= w_revert.tag;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head       <= '0;
      r_tail       <= free_list_ptr_t'(FREE_LIST_DEPTH);  // wrap bit set: full
      for (int t = 0; t < NUM_PHYS_REGS; t++)
        r_is_free[t] <= (t >= NUM_ARCH_REGS);
      r_free_count <= free_count_t'(FREE_LIST_DEPTH);
      r_dut_error  <= 1'b0;
    end else begin
      r_head       <= w_head_next;
      r_tail       <= w_tail_next;
      if (w_deq)  r_is_free[w_head_tag]   <= 1'b0;
      if (w_c_ok) r_is_free[w_commit.tag] <= 1'b1;
      if (w_r_ok) r_is_free[w_revert.tag] <= 1'b1;
      r_free_count <= free_count_t'(w_cnt_sum);
      r_dut_error  <= w_next_err;
    end
  end

  // Pointer distance, occupancy counter and bitmap population must agree.
  a_cnt_ptr : assert property (@(posedge CLK) disable iff (RST)
    free_count_t'(r_tail - r_head) == r_free_count);
  a_cnt_map : assert property (@(posedge CLK) disable iff (RST)
    $countones(r_is_free) == int'(r_free_count));

endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  phys_reg_free_list_if fl();

  phys_reg_free_list dut (
    .CLK (CLK),
    .RST (RST),
    .fl  (fl)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents (scoreboard), free bitmap, expected error.
  logic [5:0] sb[$];
  bit         mfree [64];
  bit         m_err;

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 32; i++) sb.push_back(6'(32 + i));
    for (int t = 0; t < 64; t++) mfree[t] = (t >= 32);
    m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    fl.alloc_ready              = 1'b0;
    fl.commit_free_valid        = 1'b0;
    fl.commit_free_phys_reg_tag = '0;
    fl.revert_free_valid        = 1'b0;
    fl.revert_free_phys_reg_tag = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
  endtask

  // Drive one cycle, then advance the model by what the spec says happens.
  task automatic apply(input bit ar, input bit cv, input logic [5:0] ct,
                       input bit rv, input logic [5:0] rt);
    bit deq, c_ok, r_ok, e;
    int n;
    e   = 1'b0;
    deq = ar && (sb.size() != 0);
    if (ar && sb.size() == 0) e = 1'b1;
    c_ok = cv;
    if (cv && (ct == 0 || mfree[ct])) begin c_ok = 1'b0; e = 1'b1; end
    r_ok = rv;
    if (rv && (rt == 0 || mfree[rt])) begin r_ok = 1'b0; e = 1'b1; end
    if (cv && rv && ct == rt) begin r_ok = 1'b0; e = 1'b1; end
    n = sb.size() - int'(deq) + int'(c_ok) + int'(r_ok);
    if (n > 32 && r_ok) begin r_ok = 1'b0; n--; e = 1'b1; end
    if (n > 32 && c_ok) begin c_ok = 1'b0; n--; e = 1'b1; end

    fl.alloc_ready              = ar;
    fl.commit_free_valid        = cv;
    fl.commit_free_phys_reg_tag = ct;
    fl.revert_free_valid        = rv;
    fl.revert_free_phys_reg_tag = rt;
    @(posedge CLK);
    #1 idle_inputs();

    if (deq) begin mfree[sb[0]] = 1'b0; void'(sb.pop_front()); end
    if (c_ok) begin sb.push_back(ct); mfree[ct] = 1'b1; end
    if (r_ok) begin sb.push_back(rt); mfree[rt] = 1'b1; end
    m_err = e;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if (fl.free_count !== 6'd32) begin n_fail++; $display("FAIL reset_count got=%0d exp=32", fl.free_count); end
    RST = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    n_checks++;
    if (fl.alloc_valid !== 1'b1) begin n_fail++; $display("FAIL reset_valid got=%0b exp=1", fl.alloc_valid); end
    n_checks++;
    if (fl.alloc_phys_reg_tag !== 6'd32) begin n_fail++; $display("FAIL reset_tag got=%0d exp=32", fl.alloc_phys_reg_tag); end
    n_checks++;
    if (fl.DUT_error !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", fl.DUT_error); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (fl.alloc_phys_reg_tag !== sb[0] || sb[0] !== 6'(32 + i))
        begin n_fail++; $display("FAIL drain_tag i=%0d got=%0d exp=%0d", i, fl.alloc_phys_reg_tag, 32 + i); end
      apply(1, 0, 0, 0, 0);
    end
    n_checks++;
    if (fl.alloc_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%0b exp=0", fl.alloc_valid); end
    n_checks++;
    if (fl.free_count !== 6'd0) begin n_fail++; $display("FAIL drain_count got=%0d exp=0", fl.free_count); end
    n_checks++;
    if (fl.DUT_error !== 1'b0) begin n_fail++; $display("FAIL drain_err got=%0b exp=0", fl.DUT_error); end
    // Allocating from an empty list is illegal and must not move anything.
    apply(1, 0, 0, 0, 0);
    n_checks++;
    if (fl.DUT_error !== m_err) begin n_fail++; $display("FAIL empty_alloc_err got=%0b exp=%0b", fl.DUT_error, m_err); end
    n_checks++;
    if (fl.free_count !== 6'd0) begin n_fail++; $display("FAIL empty_alloc_count got=%0d exp=0", fl.free_count); end
  endtask

  task automatic test_dual_enq();
    apply(0, 1, 6'd40, 1, 6'd50);
    n_checks++;
    if (fl.free_count !== 6'd2) begin n_fail++; $display("FAIL dual_count got=%0d exp=2", fl.free_count); end
    n_checks++;
    if (fl.alloc_phys_reg_tag !== 6'd40 || sb[0] !== 6'd40)
      begin n_fail++; $display("FAIL dual_head got=%0d exp=40", fl.alloc_phys_reg_tag); end
    n_checks++;
    if (fl.DUT_error !== 1'b0) begin n_fail++; $display("FAIL dual_err got=%0b exp=0", fl.DUT_error); end
    apply(1, 0, 0, 0, 0);
    n_checks++;
    if (fl.alloc_phys_reg_tag !== sb[0] || sb[0] !== 6'd50)
      begin n_fail++; $display("FAIL dual_second got=%0d exp=50", fl.alloc_phys_reg_tag); end
    apply(1, 0, 0, 0, 0);
    n_checks++;
    if (fl.alloc_valid !== 1'b0) begin n_fail++; $display("FAIL dual_empty got=%0b exp=0", fl.alloc_valid); end
  endtask

  task automatic test_full_deq_enq();
    do_reset();
    apply(1, 1, 6'd5, 0, 0);
    n_checks++;
    if (fl.free_count !== 6'd32) begin n_fail++; $display("FAIL fullswap_count got=%0d exp=32", fl.free_count); end
    n_checks++;
    if (fl.DUT_error !== 1'b0) begin n_fail++; $display("FAIL fullswap_err got=%0b exp=0", fl.DUT_error); end
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (fl.alloc_phys_reg_tag !== sb[0])
        begin n_fail++; $display("FAIL fullswap_drain i=%0d got=%0d exp=%0d", i, fl.alloc_phys_reg_tag, sb[0]); end
      if (i == 31) begin
        n_checks++;
        if (fl.alloc_phys_reg_tag !== 6'd5) begin n_fail++; $display("FAIL fullswap_last got=%0d exp=5", fl.alloc_phys_reg_tag); end
      end
      apply(1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    // 33 is still free after reset: double free, count stays 32.
    apply(0, 1, 6'd33, 0, 0);
    n_checks++;
    if (fl.DUT_error !== 1'b1) begin n_fail++; $display("FAIL dfree33_err got=%0b exp=1", fl.DUT_error); end
    n_checks++;
    if (fl.free_count !== 6'd32) begin n_fail++; $display("FAIL dfree33_count got=%0d exp=32", fl.free_count); end
    // Full list: a lone enqueue overflows.
    apply(0, 1, 6'd5, 0, 0);
    n_checks++;
    if (fl.DUT_error !== m_err || m_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got=%0b exp=1", fl.DUT_error); end
    n_checks++;
    if (fl.free_count !== 6'd32) begin n_fail++; $display("FAIL ovf_count got=%0d exp=32", fl.free_count); end
    // Full + dequeue + dual enqueue: revert is shed, commit kept.
    apply(1, 1, 6'd5, 1, 6'd6);
    n_checks++;
    if (fl.DUT_error !== 1'b1) begin n_fail++; $display("FAIL ovf2_err got=%0b exp=1", fl.DUT_error); end
    n_checks++;
    if (fl.free_count !== 6'd32) begin n_fail++; $display("FAIL ovf2_count got=%0d exp=32", fl.free_count); end
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (fl.alloc_phys_reg_tag !== sb[0])
        begin n_fail++; $display("FAIL ovf2_drain i=%0d got=%0d exp=%0d", i, fl.alloc_phys_reg_tag, sb[0]); end
      apply(1, 0, 0, 0, 0);
    end
    // Empty list now; tag 0 is never returnable.
    apply(0, 1, 6'd0, 0, 0);
    n_checks++;
    if (fl.DUT_error !== 1'b1) begin n_fail++; $display("FAIL tag0_err got=%0b exp=1", fl.DUT_error); end
    n_checks++;
    if (fl.free_count !== 6'd0) begin n_fail++; $display("FAIL tag0_count got=%0d exp=0", fl.free_count); end
    apply(0, 1, 6'd33, 0, 0);
    n_checks++;
    if (fl.DUT_error !== 1'b0) begin n_fail++; $display("FAIL ret33_err got=%0b exp=0", fl.DUT_error); end
    apply(0, 1, 6'd33, 0, 0);
    n_checks++;
    if (fl.DUT_error !== 1'b1) begin n_fail++; $display("FAIL dfree_err got=%0b exp=1", fl.DUT_error); end
    n_checks++;
    if (fl.free_count !== 6'd1) begin n_fail++; $display("FAIL dfree_count got=%0d exp=1", fl.free_count); end
    // Same tag on both paths: commit accepted, revert dropped.
    apply(0, 1, 6'd7, 1, 6'd7);
    n_checks++;
    if (fl.DUT_error !== 1'b1) begin n_fail++; $display("FAIL same_err got=%0b exp=1", fl.DUT_error); end
    n_checks++;
    if (fl.free_count !== 6'd2) begin n_fail++; $display("FAIL same_count got=%0d exp=2", fl.free_count); end
    apply(0, 0, 0, 0, 0);
    n_checks++;
    if (fl.DUT_error !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%0b exp=0", fl.DUT_error); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (fl.alloc_phys_reg_tag !== sb[0])
        begin n_fail++; $display("FAIL ill_drain i=%0d got=%0d exp=%0d", i, fl.alloc_phys_reg_tag, sb[0]); end
      apply(1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] pool[$];
    logic [5:0] t, t2;
    bit ar, rv;
    int k, it;
    do_reset();
    for (int i = 1; i < 32; i++) pool.push_back(6'(i));
    for (int r = 0; r < 100; r++) begin
      while (sb.size() != 0) begin
        n_checks++;
        if (fl.alloc_phys_reg_tag !== sb[0])
          begin n_fail++; $display("FAIL wrap_drain r=%0d got=%0d exp=%0d", r, fl.alloc_phys_reg_tag, sb[0]); end
        pool.push_back(sb[0]);
        apply(1, 0, 0, 0, 0);
        n_checks++;
        if (fl.DUT_error !== 1'b0) begin n_fail++; $display("FAIL wrap_drain_err r=%0d got=%0b exp=0", r, fl.DUT_error); end
      end
      n_checks++;
      if (fl.alloc_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty r=%0d got=%0b exp=0", r, fl.alloc_valid); end
      it = 0;
      while (sb.size() < 32 && it < 200) begin
        ar = (sb.size() != 0) && ($urandom_range(3) == 0);
        k  = $urandom_range(pool.size() - 1);
        t  = pool[k];
        pool.delete(k);
        rv = ($urandom_range(1) == 1) && (sb.size() + 2 - int'(ar) <= 32);
        t2 = '0;
        if (rv) begin
          k  = $urandom_range(pool.size() - 1);
          t2 = pool[k];
          pool.delete(k);
        end
        if (ar) begin
          n_checks++;
          if (fl.alloc_phys_reg_tag !== sb[0])
            begin n_fail++; $display("FAIL wrap_mix r=%0d got=%0d exp=%0d", r, fl.alloc_phys_reg_tag, sb[0]); end
          pool.push_back(sb[0]);
        end
        apply(ar, 1, t, rv, t2);
        n_checks++;
        if (fl.DUT_error !== 1'b0) begin n_fail++; $display("FAIL wrap_err r=%0d got=%0b exp=0", r, fl.DUT_error); end
        n_checks++;
        if (fl.free_count !== 6'(sb.size()))
          begin n_fail++; $display("FAIL wrap_count r=%0d got=%0d exp=%0d", r, fl.free_count, sb.size()); end
        it++;
      end
      n_checks++;
      if (sb.size() != 32) begin n_fail++; $display("FAIL wrap_refill r=%0d got=%0d exp=32", r, sb.size()); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 25; i++) apply(1, 0, 0, 0, 0);
    apply(0, 1, 6'd0, 0, 0);   // leave DUT_error high going into reset
    n_checks++;
    if (fl.free_count !== 6'd7 || fl.DUT_error !== 1'b1)
      begin n_fail++; $display("FAIL pre_rst got=%0d/%0b exp=7/1", fl.free_count, fl.DUT_error); end
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if (fl.free_count !== 6'd32) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=32", fl.free_count); end
    n_checks++;
    if (fl.alloc_phys_reg_tag !== 6'd32) begin n_fail++; $display("FAIL rstmid_tag got=%0d exp=32", fl.alloc_phys_reg_tag); end
    n_checks++;
    if (fl.DUT_error !== 1'b0) begin n_fail++; $display("FAIL rstmid_err got=%0b exp=0", fl.DUT_error); end
    @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_drain();
    test_dual_enq();
    test_full_deq_enq();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
